// File: rtl/mult_shift_add_if.sv
// Handshake and operand bundle for the mult_shift_add sequential multiplier.
// The master drives start/a/b; the slave (the multiplier) returns status and product.
interface mult_shift_add_if #(
    parameter int N = 32
);
    logic           start;
    logic [N-1:0]   a;
    logic [N-1:0]   b;
    logic           ready;
    logic           busy;
    logic           done;
    logic [2*N-1:0] product;

    modport master (
        output start, a, b,
        input  ready, busy, done, product
    );

    modport slave (
        input  start, a, b,
        output ready, busy, done, product
    );
endinterface

// File: rtl/mult_shift_add.sv
// Unsigned shift-and-add multiplier: one partial product per RUN cycle through a 2N-bit ripple adder.
// Optional macro MULT_SHIFT_ADD_EARLY_TERM_EN ends RUN as soon as the remaining multiplier bits are all zero.

module ripple_adder #(
    parameter int N = 32
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         carry0,
    output logic [N-1:0] sum,
    output logic         carry_out
);
    // Carry is a block-local variable so the chain stays a plain bit-serial ripple.
    always_comb begin : ripple
        logic c;
        sum = '0;
        c   = carry0;
        for (int i = 0; i < N; i++) begin
            sum[i] = a[i] ^ b[i] ^ c;
            c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        carry_out = c;
    end
endmodule

module mult_shift_add #(
    parameter int N = 32
) (
    input  logic           clk,
    input  logic           rst,
    mult_shift_add_if.slave bus
);
    localparam int CW = (N > 2) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [2*N-1:0]  acc;
    logic [2*N-1:0]  mcand_sh;
    logic [2*N-1:0]  add_operand;
    logic [2*N-1:0]  sum;
    logic [N-1:0]    mplier;
    logic [CW-1:0]   count;
    logic            last_iter;
    logic            carry_unused;

    always_comb begin
        add_operand = mplier[0] ? mcand_sh : '0;
    end

    // Carry out can never be set: acc + mcand_sh never exceeds (2^N-1)^2 < 2^(2N).
    ripple_adder #(
        .N(2 * N)
    ) u_adder (
        .a        (acc),
        .b        (add_operand),
        .carry0   (1'b0),
        .sum      (sum),
        .carry_out(carry_unused)
    );

`ifdef MULT_SHIFT_ADD_EARLY_TERM_EN
    assign last_iter = (count == CW'(N - 1)) || (mplier[N-1:1] == '0);
`else
    assign last_iter = (count == CW'(N - 1));
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.start) state_next = RUN;
            RUN:     if (last_iter) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc      <= '0;
            mcand_sh <= '0;
            mplier   <= '0;
            count    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        acc      <= '0;
                        mcand_sh <= {{N{1'b0}}, bus.a};
                        mplier   <= bus.b;
                        count    <= '0;
                    end
                end
                RUN: begin
                    acc      <= sum;
                    mcand_sh <= mcand_sh << 1;
                    mplier   <= mplier >> 1;
                    count    <= count + CW'(1);
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.ready   = (state == IDLE);
    assign bus.busy    = (state == RUN);
    assign bus.done    = (state == DONE);
    assign bus.product = acc;
endmodule

// File: tb/tb_mult_shift_add.sv
// Directed self-checking bench for mult_shift_add at N=8; run lengths follow MULT_SHIFT_ADD_EARLY_TERM_EN.
module tb_mult_shift_add;
    localparam int N = 8;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    mult_shift_add_if #(.N(N)) bus ();

    mult_shift_add #(
        .N(N)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // One full multiply from IDLE, with a stray start during DONE that must be ignored.
    task automatic run_mult(input string tag, input logic [7:0] av, input logic [7:0] bv,
                            input logic [15:0] expected, input int run_default, input int run_early);
        int cycles;
        int exp_run;
        cycles = 0;
`ifdef MULT_SHIFT_ADD_EARLY_TERM_EN
        exp_run = run_early;
`else
        exp_run = run_default;
`endif
        check({tag, "_ready_before"}, 32'(bus.ready), 32'd1);
        bus.a = av;
        bus.b = bv;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.a = 8'hA5;
        bus.b = 8'h3C;
        while (bus.busy && cycles < 64) begin
            cycles++;
            tick();
        end
        check({tag, "_run_cycles"}, 32'(cycles), 32'(exp_run));
        check({tag, "_done"}, 32'(bus.done), 32'd1);
        check({tag, "_product"}, 32'(bus.product), 32'(expected));
        bus.start = 1'b1;
        bus.a = 8'h11;
        bus.b = 8'h22;
        tick();
        bus.start = 1'b0;
        check({tag, "_ready_after"}, 32'(bus.ready), 32'd1);
        check({tag, "_busy_after"}, 32'(bus.busy), 32'd0);
        check({tag, "_product_held"}, 32'(bus.product), 32'(expected));
    endtask

    initial begin
        int cycles;
        int exp_b2b;
        logic saw_done;
`ifdef MULT_SHIFT_ADD_EARLY_TERM_EN
        exp_b2b = 3;
`else
        exp_b2b = 8;
`endif

        rst = 1'b1;
        bus.start = 1'b0;
        bus.a = '0;
        bus.b = '0;
        tick();
        tick();
        rst = 1'b0;
        check("rst_ready", 32'(bus.ready), 32'd1);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_product", 32'(bus.product), 32'h0000);

        run_mult("ff_ff", 8'hFF, 8'hFF, 16'hFE01, 8, 8);
        run_mult("0d_0b", 8'h0D, 8'h0B, 16'h008F, 8, 4);
        run_mult("5a_00", 8'h5A, 8'h00, 16'h0000, 8, 1);
        run_mult("00_b7", 8'h00, 8'hB7, 16'h0000, 8, 8);
        run_mult("80_02", 8'h80, 8'h02, 16'h0100, 8, 2);
        run_mult("ff_01", 8'hFF, 8'h01, 16'h00FF, 8, 1);
        run_mult("01_80", 8'h01, 8'h80, 16'h0080, 8, 8);

        // Start held high: one accept per IDLE cycle, none during RUN or DONE.
        bus.a = 8'h03;
        bus.b = 8'h07;
        bus.start = 1'b1;
        tick();
        check("b2b_first_busy", 32'(bus.busy), 32'd1);
        for (int k = 0; k < 2; k++) begin
            cycles = 0;
            while (bus.busy && cycles < 64) begin
                cycles++;
                tick();
            end
            check($sformatf("b2b%0d_run_cycles", k), 32'(cycles), 32'(exp_b2b));
            check($sformatf("b2b%0d_done", k), 32'(bus.done), 32'd1);
            check($sformatf("b2b%0d_product", k), 32'(bus.product), 32'h0015);
            tick();
            check($sformatf("b2b%0d_idle_ready", k), 32'(bus.ready), 32'd1);
            check($sformatf("b2b%0d_idle_product", k), 32'(bus.product), 32'h0015);
            tick();
            check($sformatf("b2b%0d_reaccept_busy", k), 32'(bus.busy), 32'd1);
            check($sformatf("b2b%0d_reaccept_clear", k), 32'(bus.product), 32'h0000);
        end
        bus.start = 1'b0;
        cycles = 0;
        while (bus.busy && cycles < 64) begin
            cycles++;
            tick();
        end
        check("b2b_tail_done", 32'(bus.done), 32'd1);
        check("b2b_tail_product", 32'(bus.product), 32'h0015);
        tick();
        check("b2b_tail_ready", 32'(bus.ready), 32'd1);

        // Reset in the middle of a run abandons it without a done pulse.
        bus.a = 8'h0D;
        bus.b = 8'h0B;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        check("midrst_partial", 32'(bus.product), 32'h0027);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_ready", 32'(bus.ready), 32'd1);
        check("midrst_busy", 32'(bus.busy), 32'd0);
        check("midrst_done", 32'(bus.done), 32'd0);
        check("midrst_product", 32'(bus.product), 32'h0000);
        saw_done = 1'b0;
        for (int k = 0; k < 12; k++) begin
            if (bus.done) saw_done = 1'b1;
            tick();
        end
        check("midrst_no_done", 32'(saw_done), 32'd0);
        check("midrst_still_idle", 32'(bus.ready), 32'd1);
        run_mult("after_rst", 8'h0D, 8'h0B, 16'h008F, 8, 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mult_shift_add.md
MULT_SHIFT_ADD -- requirements
Module: mult_shift_add

Interface
REQ-001 Parameter N, default 32: operand width in bits; legal N >= 2.
REQ-002 clk  input  1  rising-edge clock; all state updates on this edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request to begin a multiply; sampled only when ready=1.
REQ-005 a  input  N  unsigned multiplicand; captured on accept.
REQ-006 b  input  N  unsigned multiplier; captured on accept.
REQ-007 ready  output  1  high only in IDLE; block accepts start.
REQ-008 busy  output  1  high only in RUN.
REQ-009 done  output  1  single-cycle pulse, high only in DONE.
REQ-010 product  output  2N  unsigned a*b; valid from DONE until next accept.

Function
REQ-011 The block SHALL implement a three-state FSM: IDLE, RUN, DONE; ready, busy and done SHALL be mutually exclusive, registered-state decodes.
REQ-012 Accept: start=1 and state IDLE at a rising edge SHALL load acc=0, mcand_sh={N'b0,a}, mplier=b, and move to RUN.
REQ-013 start while in RUN or DONE SHALL be ignored; a and b SHALL be don't-care outside the accept edge.
REQ-014 Each RUN edge SHALL perform one iteration: if mplier[0]=1, acc <= acc + mcand_sh, else acc unchanged; then mcand_sh <= mcand_sh << 1 and mplier <= mplier >> 1.
REQ-015 The addition SHALL use one instance of the team's N-parameterised ripple adder, configured at width 2N, with carry0=0; only the low 2N sum bits SHALL be kept (the carry out is always 0 by construction).
REQ-016 An iteration counter SHALL count RUN edges from 0; RUN->DONE SHALL occur on the edge completing iteration N-1 (the default, without the Configuration macro).
REQ-017 DONE SHALL last exactly one cycle and then return to IDLE unconditionally.
REQ-018 product SHALL be driven from acc; acc SHALL hold its value in DONE and IDLE until the next accept clears it.
REQ-019 Default latency: accept at edge E0; done high during the cycle after edge EN; ready high again after edge EN+1.
REQ-020 Boundaries: a=0 or b=0 SHALL give product 0; a=b=2^N-1 SHALL give (2^N-1)^2 with no truncation.
REQ-021 A start arriving in the same cycle that DONE is high SHALL be ignored; it is accepted only once ready=1.

Reset
REQ-022 rst=1 at an edge SHALL force IDLE, acc=0, mcand_sh=0, mplier=0, counter=0, regardless of start or current state.
REQ-023 Post-reset outputs: ready=1, busy=0, done=0, product=0.
REQ-024 rst asserted mid-RUN SHALL abandon the operation with no done pulse.

Configuration
REQ-025 Macro MULT_SHIFT_ADD_EARLY_TERM_EN, when defined, SHALL add early termination: RUN->DONE SHALL also occur on the edge whose shifted mplier value becomes zero.
REQ-026 With the macro, RUN SHALL last max(1, p+1) cycles, where p is the index of the highest set bit of b (1 cycle when b=0); product values SHALL be identical to non-macro builds.
REQ-027 Without the macro, RUN SHALL last exactly N cycles for every operand pair; no early-exit logic SHALL be present.

Verification
REQ-028 N=8, rst held 2 cycles -> ready=1, busy=0, done=0, product=0x0000.
REQ-029 N=8, a=0xFF, b=0xFF, start at E0 -> busy for 8 cycles, done during the cycle after E8, product=0xFE01, ready after E9.
REQ-030 N=8, a=0x0D, b=0x0B -> product=0x008F; with macro, done during the cycle after E4; without macro, after E8.
REQ-031 N=8, a=0x5A, b=0x00 -> product=0x0000; with macro, RUN lasts 1 cycle.
REQ-032 N=8, start held high continuously, a=0x03, b=0x07 -> back-to-back products 0x0015, one accept per IDLE cycle, no start taken in RUN or DONE.
REQ-033 N=8, rst pulsed at E3 of a run -> no done pulse, product=0x0000, ready=1 on the following cycle; a fresh multiply then completes correctly.
